// File: rtl/mod_div_pow2_iter.sv
// Multi-lane iterative modular divider: data_o = data_i * 2^-k mod Q, one halving per clock.
// Optional macro MOD_DIV_POW2_RANGE_CHECK_EN enables the sticky input range error on err_o.
module mod_div_pow2_iter #(
  parameter int Q         = 3329,
  parameter int WIDTH     = 12,
  parameter int LANES     = 4,
  parameter int MAX_SHIFT = 8,
  parameter int SW        = $clog2(MAX_SHIFT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [LANES*WIDTH-1:0] data_i,
  input  logic [SW-1:0]          shift_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [LANES*WIDTH-1:0] data_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [SW-1:0]  MAX_K = SW'(MAX_SHIFT);
  localparam logic [WIDTH:0] Q_EXT = (WIDTH + 1)'(Q);

  state_t                 r_state;
  logic [LANES*WIDTH-1:0] r_lanes;
  logic [SW-1:0]          r_count;
  logic                   r_valid;

  logic                   w_accept;
  logic [SW-1:0]          w_count_in;
  logic [LANES*WIDTH-1:0] w_half;
  logic [WIDTH:0]         w_sum;

  assign ready_o    = (r_state == IDLE) || ((r_state == DONE) && ready_i);
  assign w_accept   = valid_i && ready_o;
  assign w_count_in = (shift_i > MAX_K) ? MAX_K : shift_i;
  assign valid_o    = r_valid;
  assign data_o     = r_lanes;

  // Odd values get Q added first so the halving stays exact modulo Q.
  always_comb begin
    w_half = '0;
    w_sum  = '0;
    for (int l = 0; l < LANES; l++) begin
      w_sum = {1'b0, r_lanes[l*WIDTH +: WIDTH]} +
              (r_lanes[l*WIDTH] ? Q_EXT : '0);
      w_half[l*WIDTH +: WIDTH] = w_sum[WIDTH:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_lanes <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_lanes <= data_i;
      r_count <= w_count_in;
      if (w_count_in == '0) begin
        r_state <= DONE;
        r_valid <= 1'b1;
      end else begin
        r_state <= BUSY;
        r_valid <= 1'b0;
      end
    end else begin
      case (r_state)
        BUSY: begin
          r_lanes <= w_half;
          r_count <= r_count - 1'b1;
          if (r_count == SW'(1)) begin
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOD_DIV_POW2_RANGE_CHECK_EN
  logic w_range_bad;
  logic r_err;

  always_comb begin
    w_range_bad = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (data_i[l*WIDTH +: WIDTH] >= WIDTH'(Q)) w_range_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else if (w_accept && w_range_bad) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/mod_div_pow2_iter.md
Name: mod_div_pow2_iter

Overview:
- Multi-lane iterative modular divider: computes a * 2^-k mod Q for LANES independent coefficients; one halving step per clock.
- Generalises the combinational divide-by-2 (k fixed at 1) to a run-time shift count, parametrised modulus, width and lane count, with a valid/ready handshake.
- Sits in the poly-arith datapath before the NTT/INTT output scaling and Montgomery-style normalisation.

Parameters:
- Q, 3329, modulus; odd, Q < 2^WIDTH.
- WIDTH, 12, coefficient width in bits.
- LANES, 4, parallel coefficients per transaction.
- MAX_SHIFT, 8, maximum k; SW = $clog2(MAX_SHIFT+1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- valid_i  in  1  input transaction valid
- ready_o  out  1  block can accept input
- data_i  in  LANES*WIDTH  packed coefficients, lane 0 in LSBs; each lane < Q
- shift_i  in  SW  k, number of halvings
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- data_o  out  LANES*WIDTH  packed results, lane order as data_i
- err_o  out  1  sticky range error (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, valid_o=0, data_o=0, internal count=0, err_o=0. Reset mid-BUSY/DONE aborts the transaction; no output produced.
- States: IDLE, BUSY, DONE.
- ready_o = (state==IDLE) || (state==DONE && ready_i). Combinational from state and ready_i.
- Accept: rising edge with valid_i && ready_o. Latch data_i into lane registers and count = min(shift_i, MAX_SHIFT); shift_i > MAX_SHIFT is clamped.
  - Clamped count == 0 -> DONE (pass-through).
  - Otherwise -> BUSY.
- BUSY, each edge, all lanes in parallel: x even -> x>>1; x odd -> (x+Q)>>1, computed at WIDTH+1 bits, result truncated to WIDTH. count decrements; when count==1 at the edge, go to DONE.
- Result visible the cycle after k halvings. valid_o rises k edges after the accept edge (k=0: immediately after the accept edge).
- DONE: valid_o=1; data_o holds the lane registers and stays stable while ready_i=0 (no change in data_o or valid_o under backpressure).
- DONE with ready_i=1:
  - If valid_i is also 1: handshake completes and the new input is accepted on the same edge (back-to-back). Next state is BUSY or DONE per the new count; valid_o stays 1 only if the new count is 0.
  - Otherwise -> IDLE, valid_o=0.
- In IDLE/BUSY valid_o=0; data_o shows the internal register and is don't-care for checking.
- Output invariant: each lane < Q when its input < Q. Lanes never interact.
- Throughput: one transaction per k+1 cycles, or per cycle when k=0 and ready_i=1.

Optional Feature:
- Macro: MOD_DIV_POW2_RANGE_CHECK_EN.
- Defined: on accept, any lane of data_i >= Q sets err_o=1 (sticky until rst_n). The offending lane is still processed, result undefined; other lanes unaffected.
- Undefined: no comparators; err_o tied to 0.

Test Plan:
- Reset/idle: rst_n low -> valid_o=0, ready_o=1, err_o=0. Release with valid_i=0 -> stays IDLE.
- Single halving: lanes {0,1,2,3328}, shift_i=1 -> valid_o one edge after accept, data_o {0,1665,1,1664}.
- Multi-step: lane 1, shift_i=2 -> 2497. 256, shift_i=8 -> 1. Random lanes/shifts vs golden a*inv(2)^k mod 3329; valid_o timing exactly k edges after accept.
- Pass-through and clamp:
  - shift_i=0, data 1234 -> valid_o right after accept, data_o=1234.
  - shift_i=15 (SW=4) behaves as 8: 256 -> 1.
- Backpressure/back-to-back:
  - Hold ready_i=0 for 5 cycles in DONE -> data_o/valid_o stable, ready_o=0.
  - ready_i=1 with valid_i=1 in DONE -> new input accepted same edge, no bubble for k=0 stream of 10 vectors.
- Reset mid-operation and range check:
  - rst_n low during BUSY (shift 8) -> IDLE, no valid_o pulse.
  - With macro: input 3329 -> err_o=1 and stays set.
  - Without macro: err_o=0.
